adc_monitor_multi: RTL and testbench
====================================

Name: adc_monitor_multi

Overview:
Parametrised ADC health monitor in the adc_clk domain, the successor to the fixed single-window overflow and single-threshold level logic.
- Windowed overflow detection with a programmable count threshold (not a bit mask), a one-cycle event pulse and a sticky flag.
- NLVL independent level/overflow counters.
- Peak-magnitude hold and an atomic snapshot handshake.
- Configuration arrives already synchronised to adc_clk (after the FREEZE_TOS/SYNC_PULSE path).

Parameters:
ADC_BITS, 14, signed ADC sample width.
WIN_BITS, 16, overflow window length is 2^WIN_BITS samples.
NLVL, 2, number of level counters (1..8).
CNT_BITS, 32, width of each level counter.

Ports:
adc_clk  in  1  sole clock.
reset  in  1  synchronous, active-high reset.
adc_data  in  ADC_BITS  signed sample, valid every cycle.
adc_ovfl  in  1  ADC overrange flag for the current sample.
cfg_wr  in  1  one-cycle config write strobe.
cfg_sel  in  4  0=ovfl threshold, 1=sticky clear, 2+k=level k threshold (k<NLVL); other values are ignored.
cfg_data  in  32  config payload.
snap_req  in  1  one-cycle snapshot request.
ovfl_pulse  out  1  one-cycle overflow event.
ovfl_sticky  out  1  latched overflow flag.
snap_valid  out  1  one-cycle snapshot-ready strobe.
peak_snap  out  ADC_BITS-1  peak magnitude at snapshot.
ovfl_win_snap  out  WIN_BITS+1  overflow count of the last completed window at snapshot.
lvl_snap  out  NLVL*CNT_BITS  level counters at snapshot; counter k occupies bits [k*CNT_BITS +: CNT_BITS].

Behaviour:
Reset:
- All counters, snapshot outputs, ovfl_pulse, ovfl_sticky, snap_valid and peak are 0.
- ovfl_thresh is 0 (disabled). All lvl_thr are 0.

Magnitude:
- mag = |adc_data| on ADC_BITS-1 bits, combinational.
- The most negative code saturates to 2^(ADC_BITS-1)-1 (no wrap to 0).

Overflow window:
- win_ctr counts 0..2^WIN_BITS-1 and wraps.
- ocnt (WIN_BITS+1 bits) accumulates adc_ovfl, including the sample on the terminal cycle.
- On terminal cycle T:
  - total = ocnt + adc_ovfl.
  - At T+1: ovfl_pulse = (ovfl_thresh != 0) && (total >= ovfl_thresh); last_win = total; ocnt = 0.
- ovfl_pulse is high for exactly one cycle per qualifying window.
- Writing cfg_sel=0 loads ovfl_thresh = cfg_data[WIN_BITS:0]. The new value applies from the next terminal cycle; the window is not restarted.

Sticky flag:
- Set by ovfl_pulse.
- Cleared by cfg_wr with cfg_sel=1 and cfg_data[0]=1.
- If set and clear occur in the same cycle, set wins.

Level counters:
- lvl_thr[k] = {mode, thr[ADC_BITS-2:0]}, taken from cfg_data[ADC_BITS-1:0].
- mode=0: count +1 when mag >= thr. thr=0 makes the counter a plain sample counter.
- mode=1: count +1 when adc_ovfl=1.
- Counters saturate at 2^CNT_BITS-1 and never wrap.
- A write to level k loads its threshold and zeroes counter k in that cycle; the current sample is not counted.
- Counters are free-running and are not cleared by a snapshot.

Peak:
- peak <= max(peak, mag) every cycle.

Snapshot:
- On snap_req in cycle S:
  - At S+1, peak_snap, ovfl_win_snap (= last_win) and lvl_snap take the register values as they stood at the start of S, before the cycle-S update.
  - snap_valid = 1 at S+1 only.
  - peak <= mag(S), restarting peak tracking.
- Snapshot outputs hold until the next snapshot.
- snap_req asserted on consecutive cycles produces consecutive snapshots.
- snap_req coincident with a level-k write: the snapshot captures the pre-write value of counter k.

Reset mid-operation:
- Reset takes effect at the next clock edge and overrides every other input. Thresholds return to 0.

Latency:
- All outputs are registered; each takes one cycle from its causing event.

Test Plan:
(Bench uses WIN_BITS=4, ADC_BITS=14, NLVL=2, CNT_BITS=8.)
1. ovfl_thresh=3; adc_ovfl high on window samples 13, 14, 15 (sample 15 is the terminal cycle) -> ovfl_pulse for exactly one cycle after the terminal cycle, ovfl_sticky=1. Repeat with only samples 13 and 14 high -> no pulse.
2. Sticky set and clear in the same cycle as ovfl_pulse -> ovfl_sticky stays 1. A later clear alone -> 0.
3. adc_data=-8192 (0x2000) -> mag=8191. Level 0 thr=8191 counts it. Peak after a snapshot reads 8191.
4. Level 1 in mode=1, adc_ovfl constant 1 for 300 cycles -> lvl_snap[15:8] saturates at 255. Rewriting the threshold zeroes the counter that cycle.
5. Samples 100, 500, 200, then snap_req on the cycle carrying 200 -> peak_snap=500, snap_valid for one cycle. Next snapshot without new data -> peak_snap=200.
6. Reset asserted mid-window with ocnt=5 -> all outputs 0. The next window starts at win_ctr=0. ovfl_thresh=0 suppresses ovfl_pulse even with adc_ovfl constant 1.

Source files
------------

// File: rtl/adc_monitor_multi_if.sv
// Bus between an ADC health monitor and its host: sample stream, config, snapshot.
interface adc_monitor_multi_if #(
    parameter int unsigned ADC_BITS = 14,
    parameter int unsigned WIN_BITS = 16,
    parameter int unsigned NLVL     = 2,
    parameter int unsigned CNT_BITS = 32
);
    logic signed [ADC_BITS-1:0]      adc_data;
    logic                            adc_ovfl;
    logic                            cfg_wr;
    logic [3:0]                      cfg_sel;
    logic [31:0]                     cfg_data;
    logic                            snap_req;
    logic                            ovfl_pulse;
    logic                            ovfl_sticky;
    logic                            snap_valid;
    logic [ADC_BITS-2:0]             peak_snap;
    logic [WIN_BITS:0]               ovfl_win_snap;
    logic [NLVL*CNT_BITS-1:0]        lvl_snap;

    modport master (
        output adc_data, adc_ovfl, cfg_wr, cfg_sel, cfg_data, snap_req,
        input  ovfl_pulse, ovfl_sticky, snap_valid, peak_snap, ovfl_win_snap, lvl_snap
    );

    modport slave (
        input  adc_data, adc_ovfl, cfg_wr, cfg_sel, cfg_data, snap_req,
        output ovfl_pulse, ovfl_sticky, snap_valid, peak_snap, ovfl_win_snap, lvl_snap
    );
endinterface

// File: rtl/adc_monitor_multi.sv
// ADC health monitor: windowed overflow detection, level counters, peak hold, snapshots.
module adc_monitor_multi #(
    parameter int unsigned ADC_BITS = 14,
    parameter int unsigned WIN_BITS = 16,
    parameter int unsigned NLVL     = 2,
    parameter int unsigned CNT_BITS = 32
) (
    input logic               adc_clk,
    input logic               reset,
    adc_monitor_multi_if.slave io_mon
);
    localparam int unsigned MAG_BITS  = ADC_BITS - 1;
    localparam int unsigned OCNT_BITS = WIN_BITS + 1;
    localparam logic signed [ADC_BITS-1:0] ADC_MIN = {1'b1, {(ADC_BITS-1){1'b0}}};

    logic [ADC_BITS-1:0]       w_neg;
    logic [MAG_BITS-1:0]       w_mag;
    logic                      w_term;
    logic [OCNT_BITS-1:0]      w_total;
    logic                      w_pulse_set;
    logic                      w_sticky_clr;
    logic                      w_othr_wr;
    logic [NLVL-1:0]           w_lvl_wr;
    logic [NLVL-1:0]           w_lvl_hit;
    logic [NLVL*CNT_BITS-1:0]  w_lvl_flat;
    logic [MAG_BITS-1:0]       w_peak_max;

    logic [WIN_BITS-1:0]       r_win_ctr;
    logic [OCNT_BITS-1:0]      r_ocnt;
    logic [OCNT_BITS-1:0]      r_last_win;
    logic [OCNT_BITS-1:0]      r_ovfl_thr;
    logic                      r_ovfl_pulse;
    logic                      r_ovfl_sticky;
    logic [ADC_BITS-1:0]       r_lvl_thr [NLVL];
    logic [CNT_BITS-1:0]       r_lvl_cnt [NLVL];
    logic [MAG_BITS-1:0]       r_peak;
    logic                      r_snap_valid;
    logic [MAG_BITS-1:0]       r_peak_snap;
    logic [OCNT_BITS-1:0]      r_win_snap;
    logic [NLVL*CNT_BITS-1:0]  r_lvl_snap;

    // Magnitude; the most negative code saturates instead of wrapping to zero
    assign w_neg = ADC_BITS'(-io_mon.adc_data);
    assign w_mag = !io_mon.adc_data[ADC_BITS-1]  ? io_mon.adc_data[ADC_BITS-2:0] :
                   (io_mon.adc_data == ADC_MIN)  ? {MAG_BITS{1'b1}} :
                                                   w_neg[ADC_BITS-2:0];

    assign w_term       = &r_win_ctr;
    assign w_total      = r_ocnt + OCNT_BITS'(io_mon.adc_ovfl);
    assign w_pulse_set  = w_term && (r_ovfl_thr != '0) && (w_total >= r_ovfl_thr);
    assign w_othr_wr    = io_mon.cfg_wr && (io_mon.cfg_sel == 4'd0);
    assign w_sticky_clr = io_mon.cfg_wr && (io_mon.cfg_sel == 4'd1) && io_mon.cfg_data[0];
    assign w_peak_max   = (w_mag > r_peak) ? w_mag : r_peak;

    // Per-level write decode, hit qualification and flattened counter view
    always_comb begin
        w_lvl_wr   = '0;
        w_lvl_hit  = '0;
        w_lvl_flat = '0;
        for (int k = 0; k < NLVL; k++) begin
            w_lvl_wr[k]  = io_mon.cfg_wr && (io_mon.cfg_sel == 4'(k + 2));
            w_lvl_hit[k] = r_lvl_thr[k][ADC_BITS-1] ? io_mon.adc_ovfl
                                                    : (w_mag >= r_lvl_thr[k][ADC_BITS-2:0]);
            w_lvl_flat[k*CNT_BITS +: CNT_BITS] = r_lvl_cnt[k];
        end
    end

    // Overflow window: count, close on terminal sample, qualify against threshold
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_win_ctr    <= '0;
            r_ocnt       <= '0;
            r_last_win   <= '0;
            r_ovfl_pulse <= 1'b0;
        end else begin
            r_win_ctr <= r_win_ctr + WIN_BITS'(1);
            if (w_term) begin
                r_ocnt       <= '0;
                r_last_win   <= w_total;
                r_ovfl_pulse <= w_pulse_set;
            end else begin
                r_ocnt       <= w_total;
                r_ovfl_pulse <= 1'b0;
            end
        end
    end

    // Overflow threshold register; takes effect at the next terminal sample
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_ovfl_thr <= '0;
        end else if (w_othr_wr) begin
            r_ovfl_thr <= io_mon.cfg_data[WIN_BITS:0];
        end
    end

    // Sticky flag; a set (new or still-visible pulse) beats a coincident clear
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_ovfl_sticky <= 1'b0;
        end else if (w_pulse_set || r_ovfl_pulse) begin
            r_ovfl_sticky <= 1'b1;
        end else if (w_sticky_clr) begin
            r_ovfl_sticky <= 1'b0;
        end
    end

    // Level thresholds and saturating counters; a write zeroes its counter
    always_ff @(posedge adc_clk) begin
        for (int k = 0; k < NLVL; k++) begin
            if (reset) begin
                r_lvl_thr[k] <= '0;
                r_lvl_cnt[k] <= '0;
            end else if (w_lvl_wr[k]) begin
                r_lvl_thr[k] <= io_mon.cfg_data[ADC_BITS-1:0];
                r_lvl_cnt[k] <= '0;
            end else if (w_lvl_hit[k] && (r_lvl_cnt[k] != {CNT_BITS{1'b1}})) begin
                r_lvl_cnt[k] <= r_lvl_cnt[k] + CNT_BITS'(1);
            end
        end
    end

    // Peak hold; a snapshot restarts tracking from the current sample
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_peak <= '0;
        end else if (io_mon.snap_req) begin
            r_peak <= w_mag;
        end else begin
            r_peak <= w_peak_max;
        end
    end

    // Snapshot capture of pre-update register state
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_snap_valid <= 1'b0;
            r_peak_snap  <= '0;
            r_win_snap   <= '0;
            r_lvl_snap   <= '0;
        end else begin
            r_snap_valid <= io_mon.snap_req;
            if (io_mon.snap_req) begin
                r_peak_snap <= r_peak;
                r_win_snap  <= r_last_win;
                r_lvl_snap  <= w_lvl_flat;
            end
        end
    end

    assign io_mon.ovfl_pulse    = r_ovfl_pulse;
    assign io_mon.ovfl_sticky   = r_ovfl_sticky;
    assign io_mon.snap_valid    = r_snap_valid;
    assign io_mon.peak_snap     = r_peak_snap;
    assign io_mon.ovfl_win_snap = r_win_snap;
    assign io_mon.lvl_snap      = r_lvl_snap;
endmodule

// File: tb/tb_adc_monitor_multi.sv
// Directed bench for adc_monitor_multi (WIN_BITS=4, ADC_BITS=14, NLVL=2, CNT_BITS=8).
module tb_adc_monitor_multi;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   smp;
    int   b_ocnt;
    int   b_last;
    int   exp_win;

    adc_monitor_multi_if #(.ADC_BITS(14), .WIN_BITS(4), .NLVL(2), .CNT_BITS(8)) mon ();

    adc_monitor_multi #(.ADC_BITS(14), .WIN_BITS(4), .NLVL(2), .CNT_BITS(8)) dut (
        .adc_clk (clk),
        .reset   (rst),
        .io_mon  (mon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock; window-position model advances with the sample just applied
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            smp    = 0;
            b_ocnt = 0;
            b_last = 0;
        end else begin
            b_ocnt += int'(mon.adc_ovfl);
            if (smp == 15) begin
                b_last = b_ocnt;
                b_ocnt = 0;
            end
            smp = (smp + 1) % 16;
        end
        mon.cfg_wr   = 1'b0;
        mon.snap_req = 1'b0;
    endtask

    task automatic drv(input logic signed [13:0] d, input logic o);
        mon.adc_data = d;
        mon.adc_ovfl = o;
        tick();
    endtask

    task automatic cfg(input logic [3:0] sel, input logic [31:0] data);
        mon.cfg_wr   = 1'b1;
        mon.cfg_sel  = sel;
        mon.cfg_data = data;
    endtask

    // Run to the end of the current window, overflow bit taken from mask[position]
    task automatic run_window(input logic [15:0] mask, input bit clr_last);
        do begin
            if (clr_last && smp == 15) cfg(4'd1, 32'd1);
            drv(14'sd0, mask[smp]);
        end while (smp != 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulse"},  32'(mon.ovfl_pulse),    32'd0);
        chk({tag, "_sticky"}, 32'(mon.ovfl_sticky),   32'd0);
        chk({tag, "_valid"},  32'(mon.snap_valid),    32'd0);
        chk({tag, "_peak"},   32'(mon.peak_snap),     32'd0);
        chk({tag, "_win"},    32'(mon.ovfl_win_snap), 32'd0);
        chk({tag, "_lvl"},    32'(mon.lvl_snap),      32'd0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        n_cmp = 0; n_err = 0; smp = 0; b_ocnt = 0; b_last = 0;
        mon.adc_data = '0; mon.adc_ovfl = 1'b0; mon.cfg_wr = 1'b0;
        mon.cfg_sel = '0; mon.cfg_data = '0; mon.snap_req = 1'b0;

        repeat (3) tick();
        chk_all_zero("rst");
        rst = 1'b0;

        // Overflow threshold 3: samples 13..15 qualify, 13..14 do not
        cfg(4'd0, 32'd3);
        run_window(16'hE000, 1'b0);
        chk("w1_pulse",  32'(mon.ovfl_pulse),  32'd1);
        chk("w1_sticky", 32'(mon.ovfl_sticky), 32'd1);
        drv(14'sd0, 1'b0);
        chk("w1_pulse_end", 32'(mon.ovfl_pulse), 32'd0);
        run_window(16'h0000, 1'b0);
        run_window(16'h6000, 1'b0);
        chk("w2_nopulse", 32'(mon.ovfl_pulse), 32'd0);

        // Sticky: clear alone, then set and clear together
        cfg(4'd1, 32'd1);
        drv(14'sd0, 1'b0);
        chk("stk_clr0", 32'(mon.ovfl_sticky), 32'd0);
        run_window(16'hE000, 1'b1);
        chk("stk_pulse",    32'(mon.ovfl_pulse),  32'd1);
        chk("stk_setwins",  32'(mon.ovfl_sticky), 32'd1);
        drv(14'sd0, 1'b0);
        chk("stk_hold", 32'(mon.ovfl_sticky), 32'd1);
        cfg(4'd1, 32'd1);
        drv(14'sd0, 1'b0);
        chk("stk_clr1", 32'(mon.ovfl_sticky), 32'd0);

        // Most negative code, level 0 threshold 8191
        cfg(4'd2, 32'h1FFF);
        drv(14'sd0, 1'b0);
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b0);
        drv(14'sh2000, 1'b0);
        drv(14'sd8190, 1'b0);
        drv(14'sh2000, 1'b0);
        drv(14'sh2000, 1'b0);
        exp_win = b_last;
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b0);
        chk("neg_valid", 32'(mon.snap_valid),    32'd1);
        chk("neg_peak",  32'(mon.peak_snap),     32'd8191);
        chk("neg_lvl0",  32'(mon.lvl_snap[7:0]), 32'd3);
        chk("neg_win",   32'(mon.ovfl_win_snap), 32'(exp_win));
        drv(14'sd0, 1'b0);
        chk("neg_valid_end", 32'(mon.snap_valid), 32'd0);
        chk("neg_peak_hold", 32'(mon.peak_snap),  32'd8191);

        // Level 1 in overflow mode saturates; rewrite zeroes it
        cfg(4'd3, 32'h2000);
        drv(14'sd0, 1'b1);
        repeat (300) drv(14'sd0, 1'b1);
        exp_win = b_last;
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b1);
        chk("sat_lvl1", 32'(mon.lvl_snap[15:8]), 32'd255);
        chk("sat_lvl0", 32'(mon.lvl_snap[7:0]),  32'd3);
        chk("sat_win",  32'(mon.ovfl_win_snap),  32'(exp_win));
        chk("sat_win16", 32'(exp_win),           32'(mon.ovfl_win_snap));
        cfg(4'd3, 32'h2000);
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b1);
        chk("wr_prewrite", 32'(mon.lvl_snap[15:8]), 32'd255);
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b0);
        chk("wr_zero", 32'(mon.lvl_snap[15:8]), 32'd0);

        // Peak tracking across consecutive snapshots
        drv(14'sd100, 1'b0);
        drv(14'sd500, 1'b0);
        mon.snap_req = 1'b1;
        drv(14'sd200, 1'b0);
        chk("pk_500",   32'(mon.peak_snap),  32'd500);
        chk("pk_valid", 32'(mon.snap_valid), 32'd1);
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b0);
        chk("pk_200",    32'(mon.peak_snap),  32'd200);
        chk("pk_valid2", 32'(mon.snap_valid), 32'd1);
        drv(14'sd0, 1'b0);
        chk("pk_valid_end", 32'(mon.snap_valid), 32'd0);

        // Reset mid-window, then thresholds are back to disabled
        run_window(16'h0000, 1'b0);
        repeat (5) drv(14'sd0, 1'b1);
        rst = 1'b1;
        tick();
        chk_all_zero("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drv(14'sd0, 1'b1);
            chk("thr0_nopulse", 32'(mon.ovfl_pulse), 32'd0);
        end
        mon.snap_req = 1'b1;
        drv(14'sd0, 1'b0);
        chk("rst_win",    32'(mon.ovfl_win_snap), 32'd16);
        chk("rst_lvl",    32'(mon.lvl_snap),      32'h1010);
        chk("rst_pulse",  32'(mon.ovfl_pulse),    32'd0);
        chk("rst_sticky", 32'(mon.ovfl_sticky),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
